tile_fetch: RTL

TILE_FETCH -- requirements
Module: tile_fetch

---
 rtl/tile_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tile_fetch.sv
// rtl/tile_fetch.sv - tile-map fetch sequencer: walks the screen in scan order, prefetching the next tile index.
module tile_fetch #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int TILE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sof,
  input  logic       pix_ce,
  output logic       rd_en,
  output logic [6:0] rd_x,
  output logic [5:0] rd_y,
  input  logic [5:0] map_data,
  output logic [5:0] tile_id,
  output logic [2:0] tile_px,
  output logic [2:0] tile_py,
  output logic [6:0] col,
  output logic [5:0] row,
  output logic       out_valid
);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [2:0] LAST_PX  = 3'(TILE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_WAIT, S_RUN} state_t;

  state_t     r_state;
  logic       r_rd_en;
  logic       r_cap;
  logic       r_valid;
  logic [6:0] r_rd_x;
  logic [5:0] r_rd_y;
  logic [5:0] r_tile_id;
  logic [5:0] r_next_tile;
  logic [2:0] r_px;
  logic [2:0] r_py;
  logic [6:0] r_col;
  logic [5:0] r_row;

  logic w_last_col;
  logic w_last_row;
  logic w_last_px;
  logic w_last_py;
  logic w_last_tile;

  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (r_row == LAST_ROW);
  assign w_last_px   = (r_px == LAST_PX);
  assign w_last_py   = (r_py == LAST_PX);
  assign w_last_tile = w_last_col && w_last_row && w_last_py;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_cap       <= 1'b0;
      r_valid     <= 1'b0;
      r_rd_x      <= '0;
      r_rd_y      <= '0;
      r_tile_id   <= '0;
      r_next_tile <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      r_rd_en <= 1'b0;
      // Map answers one clk after the strobe, so capture trails rd_en by one.
      r_cap   <= r_rd_en && (r_state == S_RUN);
      if (r_cap && !sof) begin
        r_next_tile <= map_data;
      end
      if (sof) begin
        r_state <= S_PREFETCH;
        r_rd_en <= 1'b1;
        r_rd_x  <= '0;
        r_rd_y  <= '0;
        r_valid <= 1'b0;
        r_cap   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_valid <= 1'b0;
          end
          S_PREFETCH: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            r_tile_id <= map_data;
            r_col     <= '0;
            r_row     <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_valid   <= 1'b1;
            r_state   <= S_RUN;
          end
          S_RUN: begin
            if (pix_ce) begin
              if (w_last_px) begin
                r_px      <= '0;
                r_tile_id <= r_next_tile;
                if (!w_last_col) begin
                  r_col <= r_col + 7'd1;
                end else begin
                  r_col <= '0;
                  if (!w_last_py) begin
                    r_py <= r_py + 3'd1;
                  end else begin
                    r_py <= '0;
                    if (w_last_row) begin
                      r_state <= S_IDLE;
                      r_valid <= 1'b0;
                    end else begin
                      r_row <= r_row + 6'd1;
                    end
                  end
                end
              end else begin
                r_px <= r_px + 3'd1;
                // Fetch the successor tile early, on the first pixel step of each tile.
                if ((r_px == 3'd0) && !w_last_tile) begin
                  r_rd_en <= 1'b1;
                  r_rd_x  <= w_last_col ? 7'd0 : r_col + 7'd1;
                  r_rd_y  <= (w_last_col && w_last_py) ? r_row + 6'd1 : r_row;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_en     = r_rd_en;
  assign rd_x      = r_rd_x;
  assign rd_y      = r_rd_y;
  assign tile_id   = r_tile_id;
  assign tile_px   = r_px;
  assign tile_py   = r_py;
  assign col       = r_col;
  assign row       = r_row;
  assign out_valid = r_valid;
endmodule
